// File: rtl/banzai_pkg.sv
// Shared types and default parameters for the Bayesian machine inference sequencer.
package banzai_pkg;

  localparam int unsigned DefNObs   = 8;
  localparam int unsigned DefObsW   = 2;
  localparam int unsigned DefNClass = 4;
  localparam int unsigned DefCntW   = 8;
  localparam int unsigned DefSettle = 4;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StCompute,
    StSample,
    StArgmax,
    StDone
  } seq_state_e;

endpackage

// File: rtl/banzai_argmax.sv
// Sequential argmax over packed vote counters, one class per cycle; ties keep the lowest index.
module banzai_argmax
  import banzai_pkg::*;
#(
  parameter int unsigned N_CLASS = DefNClass,
  parameter int unsigned CNT_W   = DefCntW
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start_i,
  input  logic [N_CLASS*CNT_W-1:0]   counts_i,
  output logic                       done_o,
  output logic [$clog2(N_CLASS)-1:0] best_idx_o
);

  localparam int unsigned IdxW = $clog2(N_CLASS);

  logic             active_q, active_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [IdxW-1:0]  best_idx_q, best_idx_d;
  logic [CNT_W-1:0] best_val_q, best_val_d;
  logic [CNT_W-1:0] cur_val;
  logic             last;

  assign cur_val = counts_i[idx_q*CNT_W +: CNT_W];
  assign last    = (idx_q == IdxW'(N_CLASS - 1));

  always_comb begin
    active_d   = active_q;
    idx_d      = idx_q;
    best_idx_d = best_idx_q;
    best_val_d = best_val_q;
    if (start_i) begin
      active_d = 1'b1;
      idx_d    = '0;
    end else if (active_q) begin
      // Class 0 seeds the running best; later classes must strictly beat it.
      if ((idx_q == '0) || (cur_val > best_val_q)) begin
        best_idx_d = idx_q;
        best_val_d = cur_val;
      end
      if (last) begin
        active_d = 1'b0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q   <= 1'b0;
      idx_q      <= '0;
      best_idx_q <= '0;
      best_val_q <= '0;
    end else begin
      active_q   <= active_d;
      idx_q      <= idx_d;
      best_idx_q <= best_idx_d;
      best_val_q <= best_val_d;
    end
  end

  assign done_o     = active_q && last;
  assign best_idx_o = best_idx_q;

endmodule

// File: rtl/banzai_infer_seq.sv
// Inference sequencer: loads observations, runs stochastic cycles, votes, resolves argmax.
// Define BANZAI_SEQ_SATURATE_EN to make vote counters saturate instead of wrapping.
module banzai_infer_seq
  import banzai_pkg::*;
#(
  parameter int unsigned N_OBS   = DefNObs,
  parameter int unsigned OBS_W   = DefObsW,
  parameter int unsigned N_CLASS = DefNClass,
  parameter int unsigned CNT_W   = DefCntW,
  parameter int unsigned SETTLE  = DefSettle
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start_i,
  input  logic [CNT_W-1:0]           n_cycles_i,
  input  logic [N_OBS*OBS_W-1:0]     obs_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [$clog2(N_CLASS)-1:0] result_o,
  output logic [N_CLASS*CNT_W-1:0]   count_o,
  output logic                       arr_load_o,
  output logic [$clog2(N_OBS)-1:0]   arr_addr_o,
  output logic [OBS_W-1:0]           arr_obs_o,
  output logic                       arr_en_o,
  input  logic [N_CLASS-1:0]         arr_bits_i
);

  localparam int unsigned AddrW = $clog2(N_OBS);
  localparam int unsigned SetW  = $clog2(SETTLE + 1);

  seq_state_e                      state_q, state_d;
  logic [N_OBS*OBS_W-1:0]          obs_q, obs_d;
  logic [CNT_W-1:0]                rem_q, rem_d;
  logic [AddrW-1:0]                idx_q, idx_d;
  logic [SetW-1:0]                 settle_q, settle_d;
  logic [N_CLASS-1:0][CNT_W-1:0]   cnt_q, cnt_d;
  logic                            arg_start;
  logic                            arg_done;

  function automatic logic [CNT_W-1:0] vote_inc(input logic [CNT_W-1:0] v);
`ifdef BANZAI_SEQ_SATURATE_EN
    return (v == '1) ? v : v + 1'b1;
`else
    return v + 1'b1;
`endif
  endfunction

  always_comb begin
    state_d  = state_q;
    obs_d    = obs_q;
    rem_d    = rem_q;
    idx_d    = idx_q;
    settle_d = settle_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          obs_d   = obs_i;
          rem_d   = n_cycles_i;
          idx_d   = '0;
          cnt_d   = '0;
          state_d = StLoad;
        end
      end
      StLoad: begin
        if (idx_q == AddrW'(N_OBS - 1)) begin
          idx_d    = '0;
          settle_d = '0;
          state_d  = (rem_q == '0) ? StArgmax : StCompute;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StCompute: begin
        if (settle_q == SetW'(SETTLE - 1)) begin
          state_d = StSample;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      StSample: begin
        for (int c = 0; c < int'(N_CLASS); c++) begin
          if (arr_bits_i[c]) begin
            cnt_d[c] = vote_inc(cnt_q[c]);
          end
        end
        rem_d    = rem_q - 1'b1;
        settle_d = '0;
        state_d  = (rem_q == CNT_W'(1)) ? StArgmax : StCompute;
      end
      StArgmax: begin
        if (arg_done) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Kick the scan on entry so the first class is examined in the first ARGMAX cycle.
  assign arg_start = (state_d == StArgmax) && (state_q != StArgmax);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      obs_q    <= '0;
      rem_q    <= '0;
      idx_q    <= '0;
      settle_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      obs_q    <= obs_d;
      rem_q    <= rem_d;
      idx_q    <= idx_d;
      settle_q <= settle_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    busy_o     = (state_q != StIdle) && (state_q != StDone);
    done_o     = (state_q == StDone);
    arr_load_o = (state_q == StLoad);
    arr_en_o   = (state_q == StCompute);
    arr_addr_o = '0;
    arr_obs_o  = '0;
    if (arr_load_o) begin
      arr_addr_o = idx_q;
      arr_obs_o  = obs_q[idx_q*OBS_W +: OBS_W];
    end
  end

  assign count_o = cnt_q;

  banzai_argmax #(
    .N_CLASS(N_CLASS),
    .CNT_W  (CNT_W)
  ) u_argmax (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (arg_start),
    .counts_i  (cnt_q),
    .done_o    (arg_done),
    .best_idx_o(result_o)
  );

endmodule

// File: tb/tb_banzai_infer_seq.sv
// Scoreboard bench for banzai_infer_seq: randomized vote patterns against a counting model.
module tb_banzai_infer_seq;

  localparam int N_OBS   = 8;
  localparam int OBS_W   = 2;
  localparam int N_CLASS = 4;
  localparam int CNT_W   = 8;
  localparam int SETTLE  = 4;

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic                       start_i;
  logic [CNT_W-1:0]           n_cycles_i;
  logic [N_OBS*OBS_W-1:0]     obs_i;
  logic                       busy_o;
  logic                       done_o;
  logic [$clog2(N_CLASS)-1:0] result_o;
  logic [N_CLASS*CNT_W-1:0]   count_o;
  logic                       arr_load_o;
  logic [$clog2(N_OBS)-1:0]   arr_addr_o;
  logic [OBS_W-1:0]           arr_obs_o;
  logic                       arr_en_o;
  logic [N_CLASS-1:0]         arr_bits_i = '0;

  banzai_infer_seq #(
    .N_OBS  (N_OBS),
    .OBS_W  (OBS_W),
    .N_CLASS(N_CLASS),
    .CNT_W  (CNT_W),
    .SETTLE (SETTLE)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (start_i),
    .n_cycles_i(n_cycles_i),
    .obs_i     (obs_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .result_o  (result_o),
    .count_o   (count_o),
    .arr_load_o(arr_load_o),
    .arr_addr_o(arr_addr_o),
    .arr_obs_o (arr_obs_o),
    .arr_en_o  (arr_en_o),
    .arr_bits_i(arr_bits_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N_OBS*OBS_W-1:0]   obs;
    int                       n;
    logic [N_CLASS*CNT_W-1:0] counts;
    int                       res;
    int                       t0;
  } exp_t;

  exp_t               exp_q[$];
  logic [N_CLASS-1:0] pat_q[$];
  int                 total = 0;
  int                 bad = 0;
  int                 cyc = 0;
  int                 done_cnt = 0;
  int                 last_lat = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string nm, logic [63:0] act, logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, req, $time);
    end
  endfunction

  // Array model: a new pattern appears as each compute burst starts, held through its sample.
  logic drv_prev_en = 1'b0;
  always @(negedge clk) begin
    if (arr_en_o && !drv_prev_en) begin
      arr_bits_i = (pat_q.size() > 0) ? pat_q.pop_front() : '0;
    end else if (!arr_en_o && !drv_prev_en) begin
      arr_bits_i = N_CLASS'($urandom);
    end
    drv_prev_en = arr_en_o;
  end

  // Monitor: checks load traffic and, on each done pulse, the oldest expected result.
  int ld_cnt = 0;
  int en_cnt = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      ld_cnt = 0;
      en_cnt = 0;
    end else begin
      if (arr_load_o) begin
        if (exp_q.size() == 0) begin
          check("load_unexpected", 64'(arr_load_o), 64'd0);
        end else begin
          logic [N_OBS*OBS_W-1:0] ob;
          ob = exp_q[0].obs;
          check("load_addr", 64'(arr_addr_o), 64'(ld_cnt));
          check("load_obs", 64'(arr_obs_o), 64'(ob[ld_cnt*OBS_W +: OBS_W]));
        end
        ld_cnt++;
      end else begin
        check("addr_obs_idle_zero", 64'({arr_addr_o, arr_obs_o}), 64'd0);
      end
      if (arr_en_o) en_cnt++;
      if (done_o) begin
        if (exp_q.size() == 0) begin
          check("done_unexpected", 64'(done_o), 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          last_lat = cyc - e.t0;
          check("latency", 64'(last_lat),
                64'(N_OBS + e.n * (SETTLE + 1) + N_CLASS + 1));
          check("counts", 64'(count_o), 64'(e.counts));
          check("result", 64'(result_o), 64'(e.res));
          check("load_cycles", 64'(ld_cnt), 64'(N_OBS));
          check("en_cycles", 64'(en_cnt), 64'(e.n * SETTLE));
        end
        ld_cnt = 0;
        en_cnt = 0;
        done_cnt++;
      end
    end
  end

  // mode 0: constant a; mode 1: alternate a,b; mode 2: random.
  task automatic issue_tx(input int n, input int mode, input logic [N_CLASS-1:0] a,
                          input logic [N_CLASS-1:0] b);
    exp_t               e;
    int                 sum[N_CLASS];
    logic [N_CLASS-1:0] p;
    int                 best;
    int                 v;
    for (int c = 0; c < N_CLASS; c++) sum[c] = 0;
    for (int k = 0; k < n; k++) begin
      if (mode == 0) p = a;
      else if (mode == 1) p = (k % 2 == 0) ? a : b;
      else p = N_CLASS'($urandom);
      pat_q.push_back(p);
      for (int c = 0; c < N_CLASS; c++) sum[c] += int'(p[c]);
    end
    e.counts = '0;
    best = 0;
    for (int c = 0; c < N_CLASS; c++) begin
`ifdef BANZAI_SEQ_SATURATE_EN
      v = (sum[c] > (1 << CNT_W) - 1) ? (1 << CNT_W) - 1 : sum[c];
`else
      v = sum[c] % (1 << CNT_W);
`endif
      e.counts[c*CNT_W +: CNT_W] = CNT_W'(v);
      sum[c] = v;
      if (sum[c] > sum[best]) best = c;
    end
    e.res = best;
    e.n   = n;
    e.obs = (N_OBS*OBS_W)'($urandom);
    @(negedge clk);
    start_i    = 1'b1;
    n_cycles_i = CNT_W'(n);
    obs_i      = e.obs;
    e.t0       = cyc;
    exp_q.push_back(e);
    @(negedge clk);
    start_i    = 1'b0;
    n_cycles_i = CNT_W'($urandom);
    obs_i      = (N_OBS*OBS_W)'($urandom);
    check("busy_after_start", 64'(busy_o), 64'd1);
  endtask

  task automatic wait_tx(input int n);
    int d0;
    int bound;
    bit seen;
    d0    = done_cnt;
    bound = N_OBS + n * (SETTLE + 1) + N_CLASS + 20;
    seen  = 0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk);
      if (done_cnt != d0) seen = 1;
    end
    if (!seen) begin
      check("done_timeout", 64'd0, 64'd1);
      exp_q.delete();
      pat_q.delete();
    end
    @(negedge clk);
    check("busy_after_done", 64'(busy_o), 64'd0);
  endtask

  task automatic run_tx(input int n, input int mode, input logic [N_CLASS-1:0] a,
                        input logic [N_CLASS-1:0] b);
    issue_tx(n, mode, a, b);
    wait_tx(n);
  endtask

  task automatic wait_en(output bit ok);
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (arr_en_o) ok = 1;
    end
    if (!ok) check("en_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int d0;
    rst_n      = 1'b0;
    start_i    = 1'b0;
    n_cycles_i = '0;
    obs_i      = '0;
    #12;
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_result", 64'(result_o), 64'd0);
    check("rst_count", 64'(count_o), 64'd0);
    check("rst_arr", 64'({arr_load_o, arr_addr_o, arr_obs_o, arr_en_o}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_tx(10, 0, 4'b0100, 4'b0000);
    check("latency_n10_is_63", 64'(last_lat), 64'd63);
    run_tx(0, 0, 4'b1111, 4'b0000);
    run_tx(4, 1, 4'b0011, 4'b0001);
    run_tx(5, 0, 4'b1010, 4'b0000);
    run_tx(255, 0, 4'b1111, 4'b0000);

    // A start pulse mid-run must not disturb the transaction in flight.
    issue_tx(10, 0, 4'b1001, 4'b0000);
    wait_en(ok);
    @(negedge clk);
    start_i    = 1'b1;
    n_cycles_i = 8'd3;
    @(negedge clk);
    start_i = 1'b0;
    wait_tx(10);

    // Reset mid-compute aborts with no completion.
    issue_tx(10, 2, 4'b0000, 4'b0000);
    wait_en(ok);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy_o), 64'd0);
    check("abort_en", 64'(arr_en_o), 64'd0);
    check("abort_count", 64'(count_o), 64'd0);
    check("abort_result_done", 64'({result_o, done_o}), 64'd0);
    exp_q.delete();
    pat_q.delete();
    d0 = done_cnt;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (80) @(negedge clk);
    check("abort_no_done", 64'(done_cnt - d0), 64'd0);
    check("abort_idle", 64'(busy_o), 64'd0);

    for (int i = 0; i < 25; i++) begin
      run_tx(int'($urandom_range(0, 12)), 2, 4'b0000, 4'b0000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
